// File: rtl/taxi_pkg.sv
// Shared taxi definitions: datapath widths, state encoding and default tariff.
// The display block reuses the tariff constants so both sides agree on pricing.
package taxi_pkg;

  localparam int FARE_W = 14;
  localparam int DIST_W = 10;
  localparam int TRIP_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned DEF_BASE_FARE   = 32'd100;
  localparam int unsigned DEF_BASE_DIST   = 32'd30;
  localparam int unsigned DEF_UNIT_DIST   = 32'd10;
  localparam int unsigned DEF_RATE        = 32'd20;
  localparam int unsigned DEF_WAIT_CYCLES = 32'd50;
  localparam int unsigned DEF_WAIT_RATE   = 32'd10;
  localparam int unsigned DEF_FARE_MAX    = 32'd9999;

  // Distance travelled beyond the flag-fall allowance, floored at zero.
  function automatic logic [TRIP_W-1:0] over_base(input logic [TRIP_W-1:0] trip,
                                                  input logic [TRIP_W-1:0] base);
    logic [TRIP_W-1:0] over;
    if (trip > base) begin
      over = trip - base;
    end else begin
      over = {TRIP_W{1'b0}};
    end
    return over;
  endfunction

endpackage

// File: rtl/fare_meter_if.sv
// Trip controls and distance in, fare/status out; clk and reset stay plain ports.
interface fare_meter_if;
  import taxi_pkg::*;

  logic              start;
  logic              waitL;
  logic              pause;
  logic [DIST_W-1:0] distance;
  logic [FARE_W-1:0] fare;
  logic [TRIP_W-1:0] trip_dist;
  logic [2:0]        state;
  logic              done;

  modport master (
    output start, waitL, pause, distance,
    input  fare, trip_dist, state, done
  );

  modport slave (
    input  start, waitL, pause, distance,
    output fare, trip_dist, state, done
  );

endinterface

// File: rtl/fare_accum.sv
// Saturating fare adder: current fare plus distance and waiting increments,
// clamped to FARE_MAX so the displayed fare never wraps.
module fare_accum
  import taxi_pkg::*;
#(
  parameter int unsigned FARE_MAX = DEF_FARE_MAX
) (
  input  logic [FARE_W-1:0] fare_in,
  input  logic [FARE_W-1:0] dist_inc,
  input  logic [FARE_W-1:0] wait_inc,
  output logic [FARE_W-1:0] fare_out
);

  localparam logic [FARE_W+1:0] MAX_WIDE = (FARE_W + 2)'(FARE_MAX);
  localparam logic [FARE_W-1:0] MAX_FARE = FARE_W'(FARE_MAX);

  logic [FARE_W+1:0] sum_s;

  // Two guard bits keep the three-way sum exact before the clamp.
  always_comb begin
    sum_s = {2'b00, fare_in} + {2'b00, dist_inc} + {2'b00, wait_inc};
    if (sum_s > MAX_WIDE) begin
      fare_out = MAX_FARE;
    end else begin
      fare_out = sum_s[FARE_W-1:0];
    end
  end

endmodule

// File: rtl/fare_meter.sv
// Taxi fare meter: flag-fall fare, per-unit distance charge past the base
// distance, and a waiting charge, driven by a start/wait/pause trip FSM.
module fare_meter
  import taxi_pkg::*;
#(
  parameter int unsigned BASE_FARE   = DEF_BASE_FARE,
  parameter int unsigned BASE_DIST   = DEF_BASE_DIST,
  parameter int unsigned UNIT_DIST   = DEF_UNIT_DIST,
  parameter int unsigned RATE        = DEF_RATE,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned WAIT_RATE   = DEF_WAIT_RATE,
  parameter int unsigned FARE_MAX    = DEF_FARE_MAX
) (
  input logic         clk,
  input logic         reset,
  fare_meter_if.slave bus
);

  localparam int unsigned       WCNT_W      = $clog2(WAIT_CYCLES + 1);
  localparam logic [FARE_W-1:0] BASE_FARE_L = FARE_W'(BASE_FARE);
  localparam logic [TRIP_W-1:0] BASE_DIST_L = TRIP_W'(BASE_DIST);
  localparam logic [TRIP_W-1:0] UNIT_DIST_L = TRIP_W'(UNIT_DIST);
  localparam logic [FARE_W-1:0] RATE_L      = FARE_W'(RATE);
  localparam logic [FARE_W-1:0] WAIT_RATE_L = FARE_W'(WAIT_RATE);
  localparam logic [WCNT_W-1:0] WCNT_LAST   = WCNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [FARE_W-1:0] fare_q, fare_d;
  logic [TRIP_W-1:0] trip_q, trip_d;
  logic [TRIP_W-1:0] acc_q, acc_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [DIST_W-1:0] prev_dist_q;
  logic              start_d_q;
  logic              arm_q;
  logic              done_q, done_d;

  logic [DIST_W-1:0] delta_s;
  logic              start_rise_s;
  logic [TRIP_W:0]   trip_sum_s;
  logic [TRIP_W-1:0] trip_new_s;
  logic [TRIP_W-1:0] acc_sum_s;
  logic              dist_step_s;
  logic              wait_wrap_s;
  logic [FARE_W-1:0] dist_inc_s;
  logic [FARE_W-1:0] wait_inc_s;
  logic [FARE_W-1:0] fare_sum_s;

  // arm_q masks the first edge after reset so a start already held high is
  // absorbed into start_d instead of being seen as a rising edge.
  assign delta_s      = bus.distance - prev_dist_q;
  assign start_rise_s = bus.start & ~start_d_q & arm_q;

  // Distance/waiting charge terms for the current cycle.
  always_comb begin
    trip_sum_s  = {1'b0, trip_q} + {{(TRIP_W - DIST_W + 1){1'b0}}, delta_s};
    trip_new_s  = trip_sum_s[TRIP_W] ? {TRIP_W{1'b1}} : trip_sum_s[TRIP_W-1:0];
    acc_sum_s   = acc_q + (over_base(trip_new_s, BASE_DIST_L) - over_base(trip_q, BASE_DIST_L));
    dist_step_s = (acc_sum_s >= UNIT_DIST_L);
    wait_wrap_s = (state_q == ST_WAIT) && (wait_cnt_q == WCNT_LAST);
    dist_inc_s  = dist_step_s ? RATE_L : {FARE_W{1'b0}};
    wait_inc_s  = wait_wrap_s ? WAIT_RATE_L : {FARE_W{1'b0}};
  end

  fare_accum #(
    .FARE_MAX (FARE_MAX)
  ) u_accum (
    .fare_in  (fare_q),
    .dist_inc (dist_inc_s),
    .wait_inc (wait_inc_s),
    .fare_out (fare_sum_s)
  );

  // Trip FSM next state plus fare, trip distance, remainder and wait counter.
  always_comb begin
    state_d    = state_q;
    fare_d     = fare_q;
    trip_d     = trip_q;
    acc_d      = acc_q;
    wait_cnt_d = wait_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_rise_s) begin
          state_d    = ST_RUN;
          fare_d     = BASE_FARE_L;
          trip_d     = {TRIP_W{1'b0}};
          acc_d      = {TRIP_W{1'b0}};
          wait_cnt_d = {WCNT_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN, ST_WAIT, ST_PAUSE: begin
        trip_d = trip_new_s;
        fare_d = fare_sum_s;
        if (dist_step_s) begin
          acc_d = acc_sum_s - UNIT_DIST_L;
        end else begin
          acc_d = acc_sum_s;
        end
        if (state_q == ST_WAIT) begin
          wait_cnt_d = wait_wrap_s ? {WCNT_W{1'b0}} : wait_cnt_q + WCNT_W'(1);
        end else begin
          wait_cnt_d = wait_cnt_q;
        end
        if (!bus.start) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (bus.pause) begin
          state_d = ST_PAUSE;
        end else if (bus.waitL) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      fare_q      <= {FARE_W{1'b0}};
      trip_q      <= {TRIP_W{1'b0}};
      acc_q       <= {TRIP_W{1'b0}};
      wait_cnt_q  <= {WCNT_W{1'b0}};
      prev_dist_q <= {DIST_W{1'b0}};
      start_d_q   <= 1'b0;
      arm_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fare_q      <= fare_d;
      trip_q      <= trip_d;
      acc_q       <= acc_d;
      wait_cnt_q  <= wait_cnt_d;
      prev_dist_q <= bus.distance;
      start_d_q   <= bus.start;
      arm_q       <= 1'b1;
      done_q      <= done_d;
    end
  end

  assign bus.fare      = fare_q;
  assign bus.trip_dist = trip_q;
  assign bus.state     = state_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fare_meter.sv
// Directed bench for fare_meter: default tariff instance plus a high base-fare
// instance sharing the same stimulus to exercise saturation.
module tb_fare_meter;
  import taxi_pkg::*;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  fare_meter_if bus ();
  fare_meter_if bus_s ();

  assign bus_s.start    = bus.start;
  assign bus_s.waitL    = bus.waitL;
  assign bus_s.pause    = bus.pause;
  assign bus_s.distance = bus.distance;

  fare_meter u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fare_meter #(
    .BASE_FARE (9990)
  ) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total      = 0;
    n_bad        = 0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.waitL    = 1'b0;
    bus.pause    = 1'b0;
    bus.distance = 10'd0;
    #12;
    check_val("rst_fare", bus.fare, 0);
    check_val("rst_trip", bus.trip_dist, 0);
    check_val("rst_state", bus.state, 0);
    check_val("rst_done", bus.done, 0);
    reset = 1'b1;
    tick();

    // Trip A: +1 per cycle up to 60 units.
    bus.start = 1'b1;
    tick();
    check_val("a_start_state", bus.state, 1);
    check_val("a_start_fare", bus.fare, 100);
    check_val("a_start_trip", bus.trip_dist, 0);
    for (int i = 1; i <= 60; i++) begin
      bus.distance = 10'(i);
      tick();
      if (i == 39) begin
        check_val("a39_fare", bus.fare, 100);
        check_val("a39_trip", bus.trip_dist, 39);
        check_val("sat39_fare", bus_s.fare, 9990);
      end
      if (i == 40) begin
        check_val("a40_fare", bus.fare, 120);
        check_val("sat40_fare", bus_s.fare, 9999);
      end
      if (i == 50) begin
        check_val("a50_fare", bus.fare, 140);
        check_val("a50_trip", bus.trip_dist, 50);
      end
      if (i == 60) begin
        check_val("a60_fare", bus.fare, 160);
        check_val("sat60_fare", bus_s.fare, 9999);
      end
    end

    // End of trip: done pulse, fare hold, distance ignored in DONE.
    bus.start = 1'b0;
    tick();
    check_val("done_state", bus.state, 4);
    check_val("done_pulse", bus.done, 1);
    check_val("done_fare", bus.fare, 160);
    tick();
    check_val("done_pulse_end", bus.done, 0);
    check_val("done_hold_fare", bus.fare, 160);
    bus.distance = 10'd1000;
    tick();
    check_val("done_hold_trip", bus.trip_dist, 60);
    check_val("done_hold_state", bus.state, 4);
    bus.start = 1'b1;
    tick();
    check_val("b_start_state", bus.state, 1);
    check_val("b_start_fare", bus.fare, 100);
    check_val("b_start_trip", bus.trip_dist, 0);

    // Trip B: +4 per cycle from 1000 across the 1020 -> 0 wrap.
    for (int k = 1; k <= 8; k++) begin
      bus.distance = 10'(1000 + 4 * k);
      tick();
      check_val($sformatf("b_trip_k%0d", k), bus.trip_dist, 4 * k);
      check_val($sformatf("b_fare_k%0d", k), bus.fare, 100);
    end
    bus.distance = 10'd11;
    tick();
    check_val("b35_trip", bus.trip_dist, 35);
    check_val("b35_fare", bus.fare, 100);

    // Waiting: charge on the 50th and 100th cycle spent in WAIT.
    bus.waitL = 1'b1;
    for (int t = 1; t <= 120; t++) begin
      tick();
      if (t == 1)   check_val("w1_state", bus.state, 2);
      if (t == 50)  check_val("w50_fare", bus.fare, 100);
      if (t == 51)  check_val("w51_fare", bus.fare, 110);
      if (t == 100) check_val("w100_fare", bus.fare, 110);
      if (t == 101) check_val("w101_fare", bus.fare, 120);
    end
    check_val("w120_fare", bus.fare, 120);
    check_val("w120_trip", bus.trip_dist, 35);
    check_val("sat_wait_fare", bus_s.fare, 9999);

    // Pause with waitL still high: entry-cycle delta counts, no waiting charge.
    bus.pause    = 1'b1;
    bus.distance = 10'd14;
    tick();
    check_val("p_entry_state", bus.state, 3);
    check_val("p_entry_trip", bus.trip_dist, 38);
    check_val("p_entry_fare", bus.fare, 120);
    for (int t = 1; t <= 39; t++) begin
      tick();
    end
    check_val("p_end_state", bus.state, 3);
    check_val("p_end_fare", bus.fare, 120);
    check_val("p_end_trip", bus.trip_dist, 38);
    bus.pause = 1'b0;
    bus.waitL = 1'b0;
    tick();
    check_val("resume_state", bus.state, 1);

    // Asynchronous reset mid-trip, released with start held high.
    #2;
    reset = 1'b0;
    #1;
    check_val("mid_rst_fare", bus.fare, 0);
    check_val("mid_rst_state", bus.state, 0);
    check_val("mid_rst_trip", bus.trip_dist, 0);
    check_val("mid_rst_sat_fare", bus_s.fare, 0);
    reset = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
    end
    check_val("start_high_idle", bus.state, 0);
    check_val("start_high_fare", bus.fare, 0);
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    check_val("restart_state", bus.state, 1);
    check_val("restart_fare", bus.fare, 100);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fare_meter.md
Name: fare_meter

Overview:
Taxi fare calculator. It reads the 10-bit running `distance` value produced by the distance counter and the same start/waitL/pause controls. It converts these into a fare in 0.1-yuan units: a flag-fall base fare covering a base distance, a per-unit distance charge beyond that, and a waiting-time charge. The fare output drives the display/billing path.

Parameters:
BASE_FARE, 100, flag-fall fare in 0.1-yuan units (10.0 yuan)
BASE_DIST, 30, distance units covered by BASE_FARE
UNIT_DIST, 10, distance units per chargeable step; must be >= 4
RATE, 20, fare added per UNIT_DIST beyond BASE_DIST
WAIT_CYCLES, 50, clk cycles in WAIT per waiting charge
WAIT_RATE, 10, fare added per WAIT_CYCLES of waiting
FARE_MAX, 9999, saturation ceiling of fare

Ports:
clk input 1 system clock, rising edge
reset input 1 asynchronous, active-low reset
start input 1 trip active (level); its rising edge begins a trip
waitL input 1 waiting (traffic light etc.)
pause input 1 meter pause
distance input 10 running distance from the distance counter; advances 0..4 per cycle and wraps mod 1024
fare output 14 current fare, 0.1-yuan units
trip_dist output 12 distance units travelled this trip, saturates at 4095
state output 3 IDLE=0, RUN=1, WAIT=2, PAUSE=3, DONE=4
done output 1 one-cycle pulse on entry to DONE

Behaviour:
- Reset (reset=0, async):
  - fare=0, trip_dist=0, state=IDLE, done=0.
  - Internal prev_dist=0, acc=0, wait_cnt=0, start_d=0.
- Every cycle:
  - prev_dist<=distance, start_d<=start.
  - delta=(distance-prev_dist) mod 1024; wrap 1023->1 gives delta=2.
- Trip start: start & !start_d in IDLE or DONE.
  - Next state RUN, fare<=BASE_FARE.
  - trip_dist<=0, acc<=0, wait_cnt<=0.
  - delta in this cycle is ignored (baseline).
- Transitions in RUN/WAIT/PAUSE, priority highest first:
  - !start -> DONE
  - pause -> PAUSE
  - waitL -> WAIT
  - else -> RUN
- Distance charge (RUN, WAIT, PAUSE only; ignored in IDLE/DONE):
  - trip_dist+=delta, saturating.
  - over=max(trip_dist-BASE_DIST,0), computed before (ob) and after (oa) the update.
  - acc+=oa-ob.
  - If acc>=UNIT_DIST: acc-=UNIT_DIST, fare+=RATE. At most one step per cycle, since delta<=4<=UNIT_DIST.
  - Delta is counted in WAIT and PAUSE too, so the counter's one-cycle lead is never lost.
- Waiting charge (state==WAIT only):
  - wait_cnt increments each cycle.
  - On reaching WAIT_CYCLES-1 it wraps to 0 and fare+=WAIT_RATE.
  - wait_cnt holds (does not clear) outside WAIT.
- Both charges in the same cycle: both are added.
- fare saturates at FARE_MAX; it never wraps.
- Latency: a distance change sampled at edge n is reflected in fare/trip_dist at edge n+1.
- DONE:
  - fare and trip_dist hold.
  - done=1 for exactly the entry cycle.
  - Stays in DONE until the next start rising edge, which resets the fare to BASE_FARE.
- start already high when reset releases: no rising edge is seen (start_d captures it), so the meter stays IDLE.
- Reset mid-trip: all outputs are immediately cleared to their reset values.
- An upstream distance reset to 0 mid-trip is indistinguishable from a wrap and is unsupported. Integration must reset both blocks together.

Decomposition:
- Shared package taxi_pkg holds:
  - state encoding constants (IDLE..DONE)
  - fare/distance widths (FARE_W=14, DIST_W=10, TRIP_W=12)
  - default tariff constants, reused by the display block
- One natural sub-module: fare_accum, the saturating adder (fare + dist_inc + wait_inc, clamp to FARE_MAX).
- The FSM, delta and acc logic stay in fare_meter.

Test Plan:
1. Reset, start rise, distance +1/cycle for 50 cycles -> fare=100 through trip_dist=39. Fare is 120 at trip_dist 40 and 140 at 50; trip_dist=50.
2. distance +4/cycle from 1020 across the wrap -> every delta=4, trip_dist increments by 4, no spurious charge.
3. After 35 units, hold waitL=1 for 120 cycles, distance static -> WAIT_RATE is added at wait cycles 50 and 100, so fare=120.
4. pause=1 for 40 cycles while distance steps once on the pause-entry cycle -> that delta is counted, no waiting charge, fare frozen afterwards.
5. Drop start -> done pulses one cycle, state=DONE, fare holds. Re-raise start -> fare=100, trip_dist=0.
6. Run with BASE_FARE override 9990 for 30 units past BASE_DIST -> fare saturates at 9999. Assert reset mid-trip -> fare=0, state=IDLE asynchronously.
